// File: rtl/ioctl_nvram_uploader_pkg.sv
// Shared types and constants for the HPS ioctl upload responder.
package ioctl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } ioctl_state_e;

    localparam int          IOCTL_ADDR_W    = 27;
    localparam logic [15:0] IOCTL_IDX_ROM   = 16'd0;
    localparam logic [15:0] IOCTL_IDX_DIP   = 16'd254;
    localparam logic [15:0] IOCTL_IDX_NVRAM = 16'd4;

endpackage

// File: rtl/ioctl_nvram_uploader_if.sv
// HPS ioctl upload pins plus the save-RAM fetch port, as seen by the uploader.
interface ioctl_nvram_uploader_if #(
    parameter int ADDR_W = 10
);
    import ioctl_pkg::*;

    logic                    ioctl_upload;
    logic [15:0]             ioctl_index;
    logic                    ioctl_rd;
    logic [IOCTL_ADDR_W-1:0] ioctl_addr;
    logic [7:0]              ioctl_din;
    logic                    ioctl_wait;
    logic                    ioctl_upload_req;
    logic [ADDR_W-1:0]       o_MEM_ADDR;
    logic                    o_MEM_RD;
    logic [7:0]              i_MEM_DATA;
    logic                    i_MEM_ACK;

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, i_MEM_DATA, i_MEM_ACK,
        output ioctl_din, ioctl_wait, ioctl_upload_req, o_MEM_ADDR, o_MEM_RD
    );

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, i_MEM_DATA, i_MEM_ACK,
        input  ioctl_din, ioctl_wait, ioctl_upload_req, o_MEM_ADDR, o_MEM_RD
    );

endinterface

// File: rtl/ioctl_nvram_uploader_dirty_holdoff_timer.sv
// Dirty flag with a reloadable quiet-period counter; pulses o_expire when the
// save region has been untouched for HOLDOFF running cycles.
module dirty_holdoff_timer #(
    parameter logic [23:0] HOLDOFF = 24'd6_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_dirty,
    input  logic i_pause,
    output logic o_expire
);

    logic        flag_q, flag_d;
    logic [23:0] cnt_q, cnt_d;
    logic        exp_q, exp_d;

    // Expiry is decided on the step to zero so the registered pulse lands
    // exactly HOLDOFF+1 cycles after the last dirty pulse.
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        exp_d  = 1'b0;
        if (i_dirty) begin
            flag_d = 1'b1;
            cnt_d  = HOLDOFF;
        end else if (flag_q && !i_pause) begin
            if (cnt_q <= 24'd1) begin
                flag_d = 1'b0;
                cnt_d  = 24'd0;
                exp_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
            cnt_q  <= 24'd0;
            exp_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
            exp_q  <= exp_d;
        end
    end

    assign o_expire = exp_q;

endmodule

// File: rtl/ioctl_nvram_uploader.sv
// Serves HPS upload byte reads from the core save RAM, stalling with ioctl_wait,
// and requests an upload once core writes to the save region go quiet.
module ioctl_nvram_uploader
    import ioctl_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter int          SIZE     = 1024,
    parameter logic [15:0] NV_INDEX = 16'd4,
    parameter logic [23:0] HOLDOFF  = 24'd6_000_000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic                   i_EMU_MCLK,
    input  logic                   i_EMU_RST_n,
    ioctl_nvram_uploader_if.slave  bus,
    input  logic                   i_DIRTY,
    output logic                   o_BUSY,
    output logic                   o_ERR
);

    localparam logic [IOCTL_ADDR_W-1:0] SIZE_A = IOCTL_ADDR_W'(SIZE);

    ioctl_state_e      state_q, state_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              err_q, err_d;

    logic sel;
    logic in_range;

    assign sel      = bus.ioctl_rd && bus.ioctl_upload && (bus.ioctl_index == NV_INDEX);
    assign in_range = bus.ioctl_addr < SIZE_A;

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (sel) begin
                    if (in_range) begin
                        addr_d  = bus.ioctl_addr[ADDR_W-1:0];
                        rd_d    = 1'b1;
                        wait_d  = 1'b1;
                        tmo_d   = TIMEOUT;
                        state_d = FETCH;
                    end else begin
                        din_d = 8'hFF;
                    end
                end
            end
            FETCH: begin
                // An aborted session wins over a same-cycle ack; the byte is dropped.
                if (!bus.ioctl_upload) begin
                    wait_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.i_MEM_ACK) begin
                    din_d   = bus.i_MEM_DATA;
                    state_d = DONE;
                end else if (tmo_q == 8'd0) begin
                    din_d   = 8'hFF;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
            end
            DONE: begin
                wait_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                wait_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            state_q <= IDLE;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign bus.o_MEM_ADDR = addr_q;
    assign bus.o_MEM_RD   = rd_q;
    assign o_BUSY         = (state_q != IDLE);
    assign o_ERR          = err_q;

    dirty_holdoff_timer #(
        .HOLDOFF (HOLDOFF)
    ) u_holdoff (
        .clk      (i_EMU_MCLK),
        .rst_n    (i_EMU_RST_n),
        .i_dirty  (i_DIRTY),
        .i_pause  (bus.ioctl_upload),
        .o_expire (bus.ioctl_upload_req)
    );

endmodule
